inst_rom: RTL and testbench
===========================

Name: inst_rom

Overview:
Instruction memory that services the fetch interface driven by the program-counter register. The PC side supplies a word address and chip enable. This block returns the addressed instruction word one cycle later, qualified by a valid flag. Contents are written through a load port, under a small state machine, before execution starts, so the same RTL serves simulation and FPGA bring-up without a hard-coded image.

Parameters:
ADDR_W, 6, word-address width; matches the PC width.
DATA_W, 32, instruction word width.
DEPTH, 2**ADDR_W, number of words; the whole address space is backed, so no out-of-range case exists.
NOP_WORD, 32'h0000_0000, value driven on inst whenever no valid fetch data is present.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  synchronous active-high reset.
ce  in  1  fetch enable from the PC register.
addr  in  ADDR_W  fetch word address from the PC register.
load_valid  in  1  load beat present.
load_ready  out  1  block accepts a load beat this cycle.
load_addr  in  ADDR_W  word address for the load beat.
load_data  in  DATA_W  word to store.
load_last  in  1  marks the final load beat.
inst  out  DATA_W  fetched instruction.
inst_valid  out  1  inst holds a real fetch result.
loaded  out  1  image is complete; fetches are honoured.
fetch_err  out  1  sticky flag: ce was asserted while not loaded.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state goes to EMPTY.
  - Outputs: inst=NOP_WORD, inst_valid=0, loaded=0, fetch_err=0, load_ready=0.
  - Memory array contents are not cleared.
- States and transitions:
  - EMPTY -> LOAD on the first cycle after reset deasserts (unconditional).
  - LOAD: load_ready=1. A beat is accepted when load_valid && load_ready; load_data is written to mem[load_addr] at that edge. An accepted beat with load_last=1 moves to RUN.
  - RUN: load_ready=0 and loaded=1. load_valid is ignored and causes no writes. RUN is left only by rst.
- Fetch, with state RUN and ce=1 at edge N: at N+1, inst=mem[addr] sampled at edge N and inst_valid=1. Latency is exactly 1 cycle; back-to-back fetches are sustained every cycle.
- Fetch with ce=0 at edge N: at N+1, inst=NOP_WORD and inst_valid=0. This matches the PC holding its address at 0 while ce is low.
- ce=1 while state is EMPTY or LOAD:
  - inst=NOP_WORD and inst_valid=0 next cycle.
  - fetch_err is set and stays set until rst.
- Load beat and fetch at the same edge cannot both take effect: loads happen only in LOAD and fetches only in RUN. The final load beat's data is readable by a fetch issued on the first RUN cycle.
- Repeated load_addr within one image: the last write wins.
- Reset mid-load: the partial image stays in the array, the state returns to EMPTY, and a fresh load sequence is required before loaded asserts.
- Reset mid-fetch: inst and inst_valid are forced to reset values at the reset edge; an in-flight fetch result is discarded.
- Array: single write port, single synchronous read port; inferable as block RAM.

Optional Feature:
Macro INST_ROM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit computed from load_data at write.
  - On each RUN fetch, parity is rechecked on the read word.
  - Added output parity_err (1 bit) pulses high together with inst_valid when the check fails.
  - inst still carries the raw word.
  - parity_err resets to 0.
- Not defined: no extra storage, no parity_err port, and behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> loaded=0, load_ready=1 from the second cycle after release, inst=0, inst_valid=0, fetch_err=0.
- Load and fetch: load mem[0..3]=32'h34010001, 32'h34020002, 32'h00221820, 32'hAC030000, with load_last on the 4th beat; then ce=1 with addr=0,1,2,3 on consecutive cycles -> loaded=1; inst shows the four words one cycle after each address with inst_valid=1 on every cycle.
- Early fetch: ce=1 during LOAD with addr=5 -> inst=0, inst_valid=0, fetch_err=1, and fetch_err still 1 after entering RUN.
- Stall: in RUN, drive ce=1, 0, 1 with addr=2, 2, 3 -> inst_valid is 1, 0, 1 and inst is 32'h00221820, 0, 32'hAC030000.
- Reset mid-load: accept 2 beats, assert rst, then reload with mem[0]=32'hFFFFFFFF and load_last -> RUN reached; fetch addr 0 returns 32'hFFFFFFFF; load_valid asserted in RUN leaves mem[0] unchanged.
- INST_ROM_PARITY_EN: force a bit flip on stored mem[1] via hierarchical poke, then fetch addr 1 -> parity_err=1 for exactly one cycle with inst_valid=1; fetch addr 0 -> parity_err=0.

Source files
------------

// File: rtl/inst_rom.sv
// inst_rom: loadable instruction memory behind the PC fetch port.
// Optional per-word even parity: define INST_ROM_PARITY_EN.
module inst_rom #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH = 2**ADDR_W,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ADDR_W-1:0] addr,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic              loaded,
    output logic              fetch_err
`ifdef INST_ROM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

`ifdef INST_ROM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOAD,
        ST_RUN
    } state_e;

    state_e state_q, state_d;
    logic inst_valid_q, inst_valid_d;
    logic fetch_err_q, fetch_err_d;
    logic wr_en, rd_en;
    logic [MEM_W-1:0] wr_word;
    logic [MEM_W-1:0] rd_word;
    logic [MEM_W-1:0] mem [DEPTH];

    // Next state, write/read strobes and the sticky early-fetch flag.
    always_comb begin
        state_d = state_q;
        wr_en = 1'b0;
        rd_en = 1'b0;
        fetch_err_d = fetch_err_q;
        unique case (state_q)
            ST_EMPTY: state_d = ST_LOAD;
            ST_LOAD: begin
                if (load_valid) begin
                    wr_en = 1'b1;
                    if (load_last) state_d = ST_RUN;
                end
            end
            ST_RUN: rd_en = ce;
            default: state_d = ST_EMPTY;
        endcase
        if (ce && state_q != ST_RUN) fetch_err_d = 1'b1;
        inst_valid_d = rd_en;
    end

    // Stored word, with the parity bit on top when enabled.
    always_comb begin
`ifdef INST_ROM_PARITY_EN
        wr_word = {^load_data, load_data};
`else
        wr_word = load_data;
`endif
    end

    // Control state; the array itself is never cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            inst_valid_q <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_valid_q <= inst_valid_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // One write port, one registered read port: maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[load_addr] <= wr_word;
        if (rd_en) rd_word <= mem[addr];
    end

    assign inst = inst_valid_q ? rd_word[DATA_W-1:0] : NOP_WORD;
    assign inst_valid = inst_valid_q;
    assign loaded = (state_q == ST_RUN);
    assign load_ready = (state_q == ST_LOAD);
    assign fetch_err = fetch_err_q;

`ifdef INST_ROM_PARITY_EN
    // Even parity over data plus stored bit must be zero.
    assign parity_err = inst_valid_q & (^rd_word);
`endif

endmodule

// File: tb/tb_inst_rom.sv
// tb_inst_rom: directed plus randomized checks of inst_rom
// against an array-based reference model.
module tb_inst_rom;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [5:0]  addr = '0;
    logic        lv = 1'b0;
    logic        load_ready;
    logic [5:0]  la = '0;
    logic [31:0] ld = '0;
    logic        ll = 1'b0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        loaded;
    logic        fetch_err;
`ifdef INST_ROM_PARITY_EN
    logic        parity_err;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] ref_mem [64];
    bit          known [64];
    bit          flip [64];
    int          phase = 0;
    logic [31:0] e_inst = '0;
    bit          e_valid = 0;
    bit          e_err = 0;
    bit          e_perr = 0;

    inst_rom dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .addr(addr),
        .load_valid(lv),
        .load_ready(load_ready),
        .load_addr(la),
        .load_data(ld),
        .load_last(ll),
        .inst(inst),
        .inst_valid(inst_valid),
        .loaded(loaded),
        .fetch_err(fetch_err)
`ifdef INST_ROM_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, updating the model from the current inputs.
    task automatic step();
        bit rd_known;
        rd_known = 0;
        if (rst) begin
            phase = 0;
            e_valid = 0;
            e_inst = '0;
            e_err = 0;
            e_perr = 0;
        end else begin
            e_valid = (phase == 2) && ce;
            rd_known = e_valid && known[addr];
            e_inst = e_valid ? ref_mem[addr] : 32'h0;
            e_perr = e_valid && flip[addr];
            if (ce && phase != 2) e_err = 1;
            if (phase == 1 && lv) begin
                ref_mem[la] = ld;
                known[la] = 1;
                flip[la] = 0;
                if (ll) phase = 2;
            end else if (phase == 0) begin
                phase = 1;
            end
        end
        @(posedge clk);
        #1;
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, e_valid});
        if (!e_valid || rd_known) chk("inst", inst, e_inst);
        chk("loaded", {31'b0, loaded}, {31'b0, phase == 2});
        chk("load_ready", {31'b0, load_ready}, {31'b0, phase == 1});
        chk("fetch_err", {31'b0, fetch_err}, {31'b0, e_err});
`ifdef INST_ROM_PARITY_EN
        chk("parity_err", {31'b0, parity_err}, {31'b0, e_perr});
`endif
    endtask

    task automatic beat(input logic [5:0] a, input logic [31:0] d,
                        input logic last);
        lv = 1'b1;
        la = a;
        ld = d;
        ll = last;
        step();
        lv = 1'b0;
        ll = 1'b0;
    endtask

    task automatic fetch(input logic [5:0] a);
        ce = 1'b1;
        addr = a;
        step();
        ce = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = '0;
            known[i] = 0;
            flip[i] = 0;
        end

        // reset then idle
        rst = 1'b1;
        step();
        step();
        chk("rst_inst", inst, 32'h0);
        chk("rst_loaded", {31'b0, loaded}, 32'h0);
        rst = 1'b0;
        step();
        chk("idle_ready", {31'b0, load_ready}, 32'h1);

        // early fetch during LOAD
        fetch(6'd5);
        chk("early_err", {31'b0, fetch_err}, 32'h1);
        chk("early_inst", inst, 32'h0);

        // load four words, then fetch back-to-back
        beat(6'd0, 32'h34010001, 1'b0);
        beat(6'd1, 32'h34020002, 1'b0);
        beat(6'd2, 32'h00221820, 1'b0);
        beat(6'd3, 32'hAC030000, 1'b1);
        chk("run_loaded", {31'b0, loaded}, 32'h1);
        chk("run_err_sticky", {31'b0, fetch_err}, 32'h1);
        ce = 1'b1;
        addr = 6'd0; step(); chk("f0", inst, 32'h34010001);
        addr = 6'd1; step(); chk("f1", inst, 32'h34020002);
        addr = 6'd2; step(); chk("f2", inst, 32'h00221820);
        addr = 6'd3; step(); chk("f3", inst, 32'hAC030000);

        // stall pattern
        addr = 6'd2; step(); chk("st0", inst, 32'h00221820);
        ce = 1'b0; step(); chk("st1", inst, 32'h0);
        chk("st1_v", {31'b0, inst_valid}, 32'h0);
        ce = 1'b1; addr = 6'd3; step(); chk("st2", inst, 32'hAC030000);
        ce = 1'b0;

        // reset mid-fetch then reset mid-load
        ce = 1'b1; addr = 6'd1; rst = 1'b1; step();
        chk("rst_fetch_v", {31'b0, inst_valid}, 32'h0);
        ce = 1'b0; rst = 1'b0; step();
        beat(6'd0, 32'h11111111, 1'b0);
        beat(6'd1, 32'h22222222, 1'b0);
        rst = 1'b1; step();
        rst = 1'b0; step();
        chk("reload_not_loaded", {31'b0, loaded}, 32'h0);
        beat(6'd0, 32'hFFFFFFFF, 1'b1);
        fetch(6'd0);
        chk("reload_f0", inst, 32'hFFFFFFFF);
        beat(6'd0, 32'h0, 1'b0);
        fetch(6'd0);
        chk("run_nowrite", inst, 32'hFFFFFFFF);

`ifdef INST_ROM_PARITY_EN
        dut.mem[1] = dut.mem[1] ^ 33'h1;
        ref_mem[1] = ref_mem[1] ^ 32'h1;
        flip[1] = 1;
        fetch(6'd1);
        chk("par_hit", {31'b0, parity_err}, 32'h1);
        chk("par_hit_v", {31'b0, inst_valid}, 32'h1);
        fetch(6'd0);
        chk("par_clean", {31'b0, parity_err}, 32'h0);
`endif

        // randomized rounds
        for (int r = 0; r < 4; r++) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            for (int i = 0; i < 400; i++) begin
                rst = ($urandom_range(0, 299) == 0);
                ce = ($urandom_range(0, 3) != 0);
                addr = 6'($urandom);
                lv = ($urandom_range(0, 2) != 0);
                la = 6'($urandom);
                ld = $urandom;
                ll = ($urandom_range(0, 39) == 0);
                step();
            end
            rst = 1'b0;
            ce = 1'b0;
            lv = 1'b0;
            ll = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
